// File: rtl/multdiv_ctrl_pkg.sv
// rtl/multdiv_ctrl_pkg.sv - shared widths, state and opcode encodings for the multiply/divide sequencer
// Contents:
//   WIDTH      operand/result width (only 32 is supported)
//   CNT_W      iteration counter width
//   ITER_LAST  counter value of the final RUN iteration
//   state_e    S_IDLE / S_RUN / S_FIX / S_DONE
//   op_e       OP_MULT / OP_DIV
package multdiv_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_ctrl_addsub.sv
// rtl/multdiv_ctrl_addsub.sv - 33-bit add/subtract slice (operand inverter + adder with carry-in)
// Ports:
//   in0   in   33  left operand
//   in1   in   33  right operand, inverted when sub=1
//   sub   in   1   0: in0 + in1, 1: in0 - in1 (in0 + ~in1 + 1)
//   sum   out  33  result
//   cout  out  1   carry out of bit 32
module multdiv_addsub_33
    import multdiv_ctrl_pkg::*;
(
    input  logic [WIDTH:0] in0,
    input  logic [WIDTH:0] in1,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           cout
);

    logic [WIDTH:0] in1_inv;

    // Inverter stage; the carry-in completes the two's complement on subtract.
    assign in1_inv = sub ? ~in1 : in1;

    assign {cout, sum} = {1'b0, in0} + {1'b0, in1_inv} + {{(WIDTH + 1){1'b0}}, sub};

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - multi-cycle signed multiply/divide sequencer around one shared 33-bit add/sub
// Build option: MULTDIV_EARLY_OUT_EN - trivial ops (DIV by zero, MULT by zero) skip RUN.
// Ports:
//   clock           in   1   rising-edge clock
//   reset_n         in   1   synchronous active-low reset
//   ctrl_MULT       in   1   start pulse, signed A*B (wins over ctrl_DIV)
//   ctrl_DIV        in   1   start pulse, signed A/B
//   data_operandA   in   32  multiplicand / dividend, sampled on the start cycle
//   data_operandB   in   32  multiplier / divisor, sampled on the start cycle
//   data_result     out  32  low product word or quotient, held until next completion
//   data_exception  out  1   overflow / divide-by-zero, valid with data_result
//   data_resultRDY  out  1   one-cycle strobe in the DONE cycle
//   busy            out  1   high in RUN, FIX and DONE
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // MULT: mcand = A, {hi,lo,qm1} = Booth partial product / multiplier.
    // DIV:  mcand = |B|, hi = signed partial remainder, lo = |A| shifting into quotient.
    op_e              op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic             start;
    op_e              start_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             trivial;

    logic [WIDTH:0]   as_in0, as_in1, as_sum;
    logic             as_sub;
    logic             as_cout_unused;

    logic [WIDTH:0]   prod_top;
    logic             mult_ovf;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign start_op = ctrl_MULT ? OP_MULT : OP_DIV;
    assign a_neg    = data_operandA[WIDTH-1];
    assign b_neg    = data_operandB[WIDTH-1];
    // |-2^31| = 2^31 still fits as an unsigned 32-bit magnitude.
    assign a_mag    = a_neg ? -data_operandA : data_operandA;
    assign b_mag    = b_neg ? -data_operandB : data_operandB;
    assign trivial  = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                                : (data_operandB == '0);

    // product[63:31] must be a pure sign extension for the low word to be exact.
    assign prod_top = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign mult_ovf = ~((&prod_top) | ~(|prod_top));

    multdiv_addsub_33 u_addsub (
        .in0  (as_in0),
        .in1  (as_in1),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout_unused)
    );

    // Operand steering for the single shared add/sub slice.
    always_comb begin
        as_in0 = hi_q;
        as_in1 = '0;
        as_sub = 1'b0;
        case (state_q)
            S_RUN: begin
                if (op_q == OP_MULT) begin
                    // Booth pair {lo[0], qm1}: 01 adds A, 10 subtracts A, 00/11 pass through.
                    as_in0 = hi_q;
                    as_in1 = (lo_q[0] ^ qm1_q) ? {mcand_q[WIDTH-1], mcand_q} : '0;
                    as_sub = lo_q[0] & ~qm1_q;
                end else begin
                    // Non-restoring step: shift next dividend bit into the remainder,
                    // subtract the divisor if the remainder is non-negative, else add it.
                    // The remainder stays within 32-bit signed range, so dropping hi[32] is safe.
                    as_in0 = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
                    as_in1 = {1'b0, mcand_q};
                    as_sub = ~hi_q[WIDTH];
                end
            end
            S_FIX: begin
                // Quotient negation for opposite-sign operands: 0 - Q.
                as_in0 = '0;
                as_in1 = {1'b0, lo_q};
                as_sub = 1'b1;
            end
            default: begin
                as_in0 = hi_q;
                as_in1 = '0;
                as_sub = 1'b0;
            end
        endcase
    end

    // Next-state logic; a start pulse in any state restarts the sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            cnt_d = '0;
`ifdef MULTDIV_EARLY_OUT_EN
            state_d = trivial ? S_FIX : S_RUN;
`else
            state_d = S_RUN;
`endif
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == ITER_LAST) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next-state.
    always_comb begin
        op_d     = op_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (start) begin
            op_d   = start_op;
            zero_d = trivial;
            hi_d   = '0;
            qm1_d  = 1'b0;
            if (start_op == OP_MULT) begin
                mcand_d = data_operandA;
                lo_d    = data_operandB;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
            end else begin
                mcand_d = b_mag;
                lo_d    = a_mag;
                neg_d   = a_neg ^ b_neg;
                ovf_d   = (data_operandA == {1'b1, {(WIDTH - 1){1'b0}}}) &&
                          (data_operandB == '1);
            end
        end else if (state_q == S_RUN) begin
            if (op_q == OP_MULT) begin
                // Arithmetic right shift of {hi, lo, qm1}.
                hi_d  = {as_sum[WIDTH], as_sum[WIDTH:1]};
                lo_d  = {as_sum[0], lo_q[WIDTH-1:1]};
                qm1_d = lo_q[0];
            end else begin
                hi_d = as_sum;
                lo_d = {lo_q[WIDTH-2:0], ~as_sum[WIDTH]};
            end
        end else if (state_q == S_FIX) begin
            // The remainder is never presented, so its final correction has no effect
            // on the quotient and is not performed.
            if (op_q == OP_MULT) begin
                // zero_q covers the early-out path where {hi, lo} was never iterated.
                result_d = zero_q ? '0 : lo_q;
                exc_d    = ~zero_q & mult_ovf;
            end else if (zero_q) begin
                result_d = '0;
                exc_d    = 1'b1;
            end else begin
                // -2^31 / -1 leaves Q = 2^31 unsigned with no negation: 32'h8000_0000.
                result_d = neg_q ? as_sum[WIDTH-1:0] : lo_q;
                exc_d    = ovf_q;
            end
        end

        rdy_d  = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_q     <= OP_MULT;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - self-checking bench for multdiv_ctrl: vector table, corner sequences, random ops
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    always #5 clock = ~clock;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: {exception, result} from plain 64-bit arithmetic.
    function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        longint p;
        pa = $signed(a);
        pb = $signed(b);
        if (m) begin
            p = pa * pb;
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        p = pa / pb;
        return {1'b0, p[31:0]};
    endfunction

    function automatic int exp_lat(input logic m, input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_OUT_EN
        if ((m && (a == 32'd0 || b == 32'd0)) || (!m && b == 32'd0)) return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Pulse a start in the current cycle, then follow it to completion.
    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee, input int el);
        int   lat;
        logic busy_bad;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        lat      = -1;
        busy_bad = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            step();
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = 1'b0;
            data_operandA = $urandom;
            data_operandB = $urandom;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (data_resultRDY === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(el));
        chk({tag, " result"}, data_result, er);
        chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, ee});
        chk({tag, " busy while running"}, {31'd0, busy_bad}, 32'd0);
        step();
        chk({tag, " rdy after done"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, " busy after done"}, {31'd0, busy}, 32'd0);
        chk({tag, " result held"}, data_result, er);
        last_res = er;
        last_exc = ee;
    endtask

    initial begin
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] e;
        logic        bad;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'd5,          32'd0,         32'd0,         1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 32'd6,          32'd7,         32'd42,        1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd100,        32'd7,         32'd14,        1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000,  32'h8000_0000, 32'd0,         1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'd0,          32'd5,         32'd0,         1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'd0,          32'd5,         32'd0,         1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0001_0000,  32'h0000_8000, 32'h8000_0000, 1'b1};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) step();
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].exc, exp_lat(vecs[i].m, vecs[i].a, vecs[i].b));
            repeat (2) step();
        end

        // DIV at cycle 0 aborted by MULT at cycle 10: only the MULT completes, at cycle 44.
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        bad = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            ctrl_DIV = 1'b0;
            if (data_resultRDY !== 1'b0) bad = 1'b1;
            if (c == 5) begin
                chk("abort result held mid-run", data_result, last_res);
                chk("abort exception held mid-run", {31'd0, data_exception}, {31'd0, last_exc});
            end
        end
        chk("abort no rdy before restart", {31'd0, bad}, 32'd0);
        do_op("abort restart", 1'b1, 1'b0, 32'd6, 32'd7, 32'd42, 1'b0, 34);

        // Reset in cycle 15 of a MULT: outputs zero from cycle 16, no strobe afterwards.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd123;
        data_operandB = 32'd456;
        for (int c = 1; c <= 15; c++) begin
            step();
            ctrl_MULT = 1'b0;
        end
        reset_n = 1'b0;
        step();
        chk("midreset result", data_result, 32'd0);
        chk("midreset exception", {31'd0, data_exception}, 32'd0);
        chk("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("midreset no late rdy", {31'd0, bad}, 32'd0);
        do_op("after reset", 1'b1, 1'b0, 32'd123, 32'd456, 32'd56088, 1'b0, 34);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            a = pick();
            b = pick();
            e = model(m, a, b);
            do_op($sformatf("rand%0d", i), m, d, a, b, e[31:0], e[32], exp_lat(m, a, b));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
